mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency unified memory between the IF-stage

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between fetch and data ports.
// Data wins by default; a bounded grant streak keeps fetch from starving.
module mem_port_arbiter #(
    parameter int MEM_LAT       = 2,
    parameter int MAX_MM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mm_req,
    input  logic        mm_we,
    input  logic [31:0] mm_addr,
    input  logic [31:0] mm_wdata,
    output logic        mm_ack,
    output logic [31:0] mm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(MAX_MM_STREAK + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MM_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_IF,
        GRANT_MM,
        BUSY_IF,
        BUSY_MM
    } arbState;

    arbState       state;
    arbState       nextState;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          ifAckReg;
    logic          mmAckReg;
    logic [31:0]   ifRdataReg;
    logic [31:0]   mmRdataReg;
    logic [31:0]   memAddrReg;
    logic [31:0]   memWdataReg;
    logic          memWeReg;
    logic          memEnComb;
    logic          lastBusyIf;
    logic          lastBusyMm;
    logic          isIdle;
    logic          ifElig;
    logic          mmElig;
    logic          grantMm;
    logic          grantIf;

    // A request whose ack is showing this cycle is the stale, finished one.
    assign isIdle  = (state == IDLE);
    assign ifElig  = if_req && !ifAckReg;
    assign mmElig  = mm_req && !mmAckReg;
    assign grantMm = isIdle && mmElig && !(ifElig && streak == STREAK_MAX);
    assign grantIf = isIdle && !grantMm && ifElig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (grantMm) begin
                    nextState = GRANT_MM;
                end else if (grantIf) begin
                    nextState = GRANT_IF;
                end
            end
            GRANT_IF: nextState = BUSY_IF;
            GRANT_MM: nextState = BUSY_MM;
            BUSY_IF:  if (cnt == '0) nextState = IDLE;
            BUSY_MM:  if (cnt == '0) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        memEnComb  = 1'b0;
        lastBusyIf = 1'b0;
        lastBusyMm = 1'b0;
        unique case (state)
            GRANT_IF: memEnComb = 1'b1;
            GRANT_MM: memEnComb = 1'b1;
            BUSY_IF:  lastBusyIf = (cnt == '0);
            BUSY_MM:  lastBusyMm = (cnt == '0);
            default:  memEnComb = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            streak      <= '0;
            ifAckReg    <= 1'b0;
            mmAckReg    <= 1'b0;
            ifRdataReg  <= '0;
            mmRdataReg  <= '0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            memWeReg    <= 1'b0;
        end else begin
            ifAckReg <= lastBusyIf;
            mmAckReg <= lastBusyMm;
            if (grantMm) begin
                memAddrReg  <= mm_addr;
                memWeReg    <= mm_we;
                memWdataReg <= mm_wdata;
                if (ifElig && streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (grantIf) begin
                memAddrReg  <= if_addr;
                memWeReg    <= 1'b0;
                memWdataReg <= '0;
                streak      <= '0;
            end
            if (memEnComb) begin
                cnt <= CNT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (lastBusyIf) begin
                ifRdataReg <= mem_rdata;
            end
            if (lastBusyMm && !memWeReg) begin
                mmRdataReg <= mem_rdata;
            end
        end
    end

    assign if_ack    = ifAckReg;
    assign if_rdata  = ifRdataReg;
    assign mm_ack    = mmAckReg;
    assign mm_rdata  = mmRdataReg;
    assign mem_en    = memEnComb;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mm_req = 1'b0;
    logic        mm_we = 1'b0;
    logic [31:0] mm_addr = '0;
    logic [31:0] mm_wdata = '0;
    logic        mm_ack;
    logic [31:0] mm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.MEM_LAT(LAT), .MAX_MM_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_ack(mm_ack), .mm_rdata(mm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return a ^ 32'h2002001A;
    endfunction

    // Memory responder state (driven by what the DUT actually issues)
    logic [31:0] memArr [logic [31:0]];
    logic [31:0] rdSched [int];
    // Reference model state (driven only by requester inputs)
    logic [31:0] modelMem [logic [31:0]];
    bit          modelOn = 0;
    int          freeCyc = 0;
    int          memEnCyc = -1;
    int          ackCyc = -1;
    bit          curMm = 0;
    bit          curWe = 0;
    logic [31:0] curAddr = '0;
    logic [31:0] curWdata = '0;
    logic [31:0] pendData = '0;
    logic [31:0] eIfR = '0;
    logic [31:0] eMmR = '0;
    logic [31:0] eAddr = '0;
    logic [31:0] eWdata = '0;
    logic        eWe = 1'b0;
    int          streak = 0;

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        return modelMem.exists(a) ? modelMem[a] : initVal(a);
    endfunction

    task automatic startAccess(input int c);
        memEnCyc = c + 1;
        ackCyc   = c + 2 + LAT;
        freeCyc  = ackCyc;
    endtask

    always @(negedge clk) begin
        bit ifE;
        bit mmE;
        if (rdSched.exists(cyc)) begin
            mem_rdata = rdSched[cyc];
            rdSched.delete(cyc);
        end else begin
            mem_rdata = $urandom;
        end
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) memArr[mem_addr] = mem_wdata;
            else rdSched[cyc + LAT] = memArr.exists(mem_addr) ? memArr[mem_addr] : initVal(mem_addr);
        end

        if (modelOn) begin
            if (cyc == memEnCyc) begin
                eAddr  = curAddr;
                eWe    = curWe;
                eWdata = curWdata;
            end
            if (cyc == ackCyc) begin
                if (!curMm) eIfR = pendData;
                else if (!curWe) eMmR = pendData;
            end
            chk("mem_en", 32'(mem_en), 32'(cyc == memEnCyc));
            chk("mem_we", 32'(mem_we), 32'(eWe));
            chk("mem_addr", mem_addr, eAddr);
            chk("mem_wdata", mem_wdata, eWdata);
            chk("if_ack", 32'(if_ack), 32'(cyc == ackCyc && !curMm));
            chk("mm_ack", 32'(mm_ack), 32'(cyc == ackCyc && curMm));
            chk("if_rdata", if_rdata, eIfR);
            chk("mm_rdata", mm_rdata, eMmR);
        end

        if (rst) begin
            modelOn  = 1;
            freeCyc  = cyc + 1;
            memEnCyc = -1;
            ackCyc   = -1;
            eIfR = '0; eMmR = '0; eAddr = '0; eWdata = '0; eWe = 1'b0;
            streak = 0;
        end else if (modelOn && cyc >= freeCyc) begin
            ifE = if_req && !(cyc == ackCyc && !curMm);
            mmE = mm_req && !(cyc == ackCyc && curMm);
            if (mmE && !(ifE && streak == MAXS)) begin
                if (ifE) streak = (streak < MAXS) ? streak + 1 : MAXS;
                curMm = 1; curAddr = mm_addr; curWe = mm_we; curWdata = mm_wdata;
                if (mm_we) modelMem[mm_addr] = mm_wdata;
                else pendData = modelRead(mm_addr);
                startAccess(cyc);
            end else if (ifE) begin
                streak = 0;
                curMm = 0; curAddr = if_addr; curWe = 0; curWdata = '0;
                pendData = modelRead(if_addr);
                startAccess(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset held 2 cycles with both requests high
        if_req = 1; if_addr = 32'h10; mm_req = 1; mm_addr = 32'h100; mm_we = 0;
        step();
        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_if_ack", 32'(if_ack), 0);
        chk("rst_mm_ack", 32'(mm_ack), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("rst_no_grant", 32'(mem_en), 0);
        step();
        if_req = 0; mm_req = 0;
        @(negedge clk);
        chk("first_grant_en", 32'(mem_en), 1);
        chk("first_grant_addr", mem_addr, 32'h100);
        repeat (3) @(negedge clk);
        chk("first_mm_ack", 32'(mm_ack), 1);
        chk("first_mm_rdata", mm_rdata, 32'h2002011A);
        idle(3);

        // IF read at 0x10
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("ifrd_en", 32'(mem_en), 1);
        chk("ifrd_addr", mem_addr, 32'h10);
        chk("ifrd_we", 32'(mem_we), 0);
        repeat (3) @(negedge clk);
        chk("ifrd_ack", 32'(if_ack), 1);
        chk("ifrd_data", if_rdata, 32'h2002000A);
        step();
        if_req = 0;
        idle(3);

        // Simultaneous requests: MM first, IF granted in the MM ack cycle
        mm_req = 1; mm_addr = 32'h100; mm_we = 0;
        if_req = 1; if_addr = 32'h20;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("sim_mm_ack", 32'(mm_ack), 1);
        chk("sim_if_ack_lo", 32'(if_ack), 0);
        chk("sim_mm_rdata", mm_rdata, 32'h2002011A);
        step();
        mm_req = 0;
        @(negedge clk);
        chk("sim_if_en", 32'(mem_en), 1);
        chk("sim_if_addr", mem_addr, 32'h20);
        repeat (3) @(negedge clk);
        chk("sim_if_ack", 32'(if_ack), 1);
        chk("sim_if_rdata", if_rdata, 32'h2002003A);
        step();
        if_req = 0;
        idle(3);

        // MM write 0x40 <= DEADBEEF
        mm_req = 1; mm_we = 1; mm_addr = 32'h40; mm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("wr_en", 32'(mem_en), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", mem_addr, 32'h40);
        chk("wr_data", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_en_once", 32'(mem_en), 0);
        repeat (2) @(negedge clk);
        chk("wr_ack", 32'(mm_ack), 1);
        chk("wr_rdata_kept", mm_rdata, 32'h2002011A);
        step();
        mm_req = 0; mm_we = 0;
        idle(3);

        // Streak saturation: fetch pulses each MM grant, fifth pulse wins
        rst = 1;
        step();
        rst = 0;
        step();
        mm_req = 1; mm_addr = 32'h80; mm_we = 0;
        for (int k = 0; k < 5; k++) begin
            if_req = 1; if_addr = 32'h30;
            step();
            if_req = 0;
            @(negedge clk);
            chk("streak_en", 32'(mem_en), 1);
            chk("streak_addr", mem_addr, (k < 4) ? 32'h80 : 32'h30);
            if (k < 4) idle(4);
        end
        idle(4);
        mm_req = 0;
        idle(6);

        // Reset two cycles into an MM read aborts it
        mm_req = 1; mm_addr = 32'h44; mm_we = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("abort_en", 32'(mem_en), 0);
        chk("abort_ack", 32'(mm_ack), 0);
        chk("abort_rdata", mm_rdata, 0);
        @(negedge clk);
        chk("abort_regrant", 32'(mem_en), 1);
        chk("abort_regrant_addr", mem_addr, 32'h44);
        repeat (3) @(negedge clk);
        chk("abort_ack2", 32'(mm_ack), 1);
        chk("abort_rdata2", mm_rdata, 32'h2002005E);
        step();
        mm_req = 0;
        idle(3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = ($urandom_range(0, 149) == 0);
            if (!if_req || if_ack) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end else begin
                if ($urandom_range(0, 15) == 0) if_req = 0;
                if ($urandom_range(0, 7) == 0) if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!mm_req || mm_ack) begin
                mm_req   = ($urandom_range(0, 2) != 0);
                mm_we    = $urandom_range(0, 1) != 0;
                mm_addr  = 32'($urandom_range(0, 63)) << 2;
                mm_wdata = $urandom;
            end else begin
                if ($urandom_range(0, 15) == 0) mm_req = 0;
                if ($urandom_range(0, 7) == 0) begin
                    mm_we    = $urandom_range(0, 1) != 0;
                    mm_addr  = 32'($urandom_range(0, 63)) << 2;
                    mm_wdata = $urandom;
                end
            end
        end
        step();
        rst = 0; if_req = 0; mm_req = 0;
        idle(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
